sc_mult_scheduler: RTL and testbench

//  Sequencer and arbiter for the shared stochastic multiplier datapath (LFSR comparators, XNOR, ones counter).
//  Two requesters each present a pair of 9-bit bipolar operands. The block grants one requester at a time,

---
 rtl/sc_sched_pkg.sv | 22 ++
 rtl/sc_rr_arb2.sv | 18 +
 rtl/sc_mult_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_sc_mult_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_sched_pkg.sv
// Shared types and defaults for the stochastic multiplier scheduler.
package sc_sched_pkg;

  localparam int OP_W_DEF     = 9;
  localparam int WIN_LOG2_DEF = 17;
  localparam int PIPE_LAT_DEF = 2;
  localparam int WIN_CYCLES   = 2 ** WIN_LOG2_DEF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sc_rr_arb2.sv
// Two-way round-robin pick: rr_ptr names the requester preferred on a tie.
// Combinational, no backpressure; win is one-hot or zero when nothing requests.
module sc_rr_arb2
  import sc_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = onehot2(rr_ptr);
    end
  end

endmodule

// File: rtl/sc_mult_scheduler.sv
// Arbitrates two operand requesters onto the shared stochastic multiplier; SC_SEED_ROTATE_EN rotates LFSR seeds.
// Latency grant -> result_valid = 1 + PIPE_LAT + 2**WIN_LOG2 + 1 cycles.
// Requests are level-held and simply wait while busy; nothing is queued beyond req.
module sc_mult_scheduler
  import sc_sched_pkg::*;
#(
  parameter int OP_W     = OP_W_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [OP_W-1:0]     op_a0,
  input  logic [OP_W-1:0]     op_b0,
  input  logic [OP_W-1:0]     op_a1,
  input  logic [OP_W-1:0]     op_b1,
  output logic [1:0]          grant,
  output logic                busy,
  output logic [OP_W-1:0]     dp_op_a,
  output logic [OP_W-1:0]     dp_op_b,
  output logic                dp_clr,
  output logic                dp_run,
  output logic [1:0]          dp_seed_idx,
  input  logic [WIN_LOG2:0]   dp_ones,
  output logic [OP_W:0]       result,
  output logic                result_valid,
  output logic                result_id
);

  state_t              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                win_id_q, win_id_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [1:0]          grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [OP_W-1:0]     dp_op_a_q, dp_op_a_d;
  logic [OP_W-1:0]     dp_op_b_q, dp_op_b_d;
  logic                dp_clr_q, dp_clr_d;
  logic                dp_run_q, dp_run_d;
  logic [OP_W:0]       result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                result_id_q, result_id_d;
  logic [1:0]          win;
  logic [OP_W-1:0]     ones_mag;
  logic                ones_unused;

`ifdef SC_SEED_ROTATE_EN
  logic [1:0]          seed_q, seed_d;
`endif

  sc_rr_arb2 u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .win    (win)
  );

  // Magnitude is the top OP_W bits of the window count, zero-filled when the window is shorter.
  if (WIN_LOG2 >= OP_W) begin : g_trunc
    assign ones_mag = dp_ones[WIN_LOG2-1 -: OP_W];
  end else begin : g_pad
    assign ones_mag = {dp_ones[WIN_LOG2-1:0], {(OP_W-WIN_LOG2){1'b0}}};
  end
  assign ones_unused = ^dp_ones;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    win_id_d       = win_id_q;
    cnt_d          = cnt_q;
    grant_d        = 2'b00;
    busy_d         = busy_q;
    dp_op_a_d      = dp_op_a_q;
    dp_op_b_d      = dp_op_b_q;
    dp_clr_d       = 1'b0;
    dp_run_d       = dp_run_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    result_id_d    = result_id_q;
`ifdef SC_SEED_ROTATE_EN
    seed_d         = seed_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = LOAD;
          win_id_d = win[1];
          rr_ptr_d = ~win[1];
          grant_d  = win;
          busy_d   = 1'b1;
          dp_clr_d = 1'b1;
`ifdef SC_SEED_ROTATE_EN
          seed_d   = seed_q + 2'd1;
`endif
        end
      end
      LOAD: begin
        dp_op_a_d = win_id_q ? op_a1 : op_a0;
        dp_op_b_d = win_id_q ? op_b1 : op_b0;
        cnt_d     = '0;
        dp_run_d  = 1'b1;
        state_d   = FLUSH;
      end
      FLUSH: begin
        if (cnt_q == WIN_LOG2'(PIPE_LAT - 1)) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          dp_run_d = 1'b0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        // A full window sets the MSB; the magnitude then reads zero rather than saturating.
        result_d       = {dp_ones[WIN_LOG2], dp_ones[WIN_LOG2] ? {OP_W{1'b0}} : ones_mag};
        result_valid_d = 1'b1;
        result_id_d    = win_id_q;
        state_d        = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d   = 1'b0;
        dp_run_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= 1'b0;
      win_id_q       <= 1'b0;
      cnt_q          <= '0;
      grant_q        <= 2'b00;
      busy_q         <= 1'b0;
      dp_op_a_q      <= '0;
      dp_op_b_q      <= '0;
      dp_clr_q       <= 1'b0;
      dp_run_q       <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_id_q    <= 1'b0;
`ifdef SC_SEED_ROTATE_EN
      seed_q         <= 2'b00;
`endif
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      win_id_q       <= win_id_d;
      cnt_q          <= cnt_d;
      grant_q        <= grant_d;
      busy_q         <= busy_d;
      dp_op_a_q      <= dp_op_a_d;
      dp_op_b_q      <= dp_op_b_d;
      dp_clr_q       <= dp_clr_d;
      dp_run_q       <= dp_run_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
`ifdef SC_SEED_ROTATE_EN
      seed_q         <= seed_d;
`endif
    end
  end

  assign grant        = grant_q;
  assign busy         = busy_q;
  assign dp_op_a      = dp_op_a_q;
  assign dp_op_b      = dp_op_b_q;
  assign dp_clr       = dp_clr_q;
  assign dp_run       = dp_run_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign result_id    = result_id_q;
`ifdef SC_SEED_ROTATE_EN
  assign dp_seed_idx  = seed_q;
`else
  assign dp_seed_idx  = 2'b00;
`endif

endmodule

// File: tb/tb_sc_mult_scheduler.sv
// Bench for sc_mult_scheduler with a 16-cycle window and a behavioural stochastic datapath.
module tb_sc_mult_scheduler;

  localparam int OP_W     = 9;
  localparam int WIN_LOG2 = 4;
  localparam int PIPE_LAT = 2;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int LAT      = 1 + PIPE_LAT + WIN + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req;
  logic [OP_W-1:0]   op_a0, op_b0, op_a1, op_b1;
  logic [1:0]        grant;
  logic              busy;
  logic [OP_W-1:0]   dp_op_a, dp_op_b;
  logic              dp_clr, dp_run;
  logic [1:0]        dp_seed_idx;
  logic [WIN_LOG2:0] dp_ones;
  logic [OP_W:0]     result;
  logic              result_valid, result_id;

  int n_checks = 0;
  int n_fail   = 0;

  // Datapath model: stream bits are counted only once PIPE_LAT run cycles have filled the pipe.
  logic [WIN_LOG2:0] m_cnt;
  int                m_run;
  logic              force_en;
  logic [WIN_LOG2:0] force_val;

  assign dp_ones = force_en ? force_val : m_cnt;

  always #5 clk = ~clk;

  sc_mult_scheduler #(.OP_W(OP_W), .WIN_LOG2(WIN_LOG2), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst), .req(req),
    .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
    .grant(grant), .busy(busy), .dp_op_a(dp_op_a), .dp_op_b(dp_op_b),
    .dp_clr(dp_clr), .dp_run(dp_run), .dp_seed_idx(dp_seed_idx), .dp_ones(dp_ones),
    .result(result), .result_valid(result_valid), .result_id(result_id)
  );

  function automatic logic sn_bit(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    logic sa, sb;
    sa = ($urandom_range(510, 0) < 32'(a));
    sb = ($urandom_range(510, 0) < 32'(b));
    return ~(sa ^ sb);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= '0;
      m_run <= 0;
    end else if (dp_clr) begin
      m_cnt <= '0;
      m_run <= 0;
    end else if (dp_run) begin
      m_run <= m_run + 1;
      if (m_run >= PIPE_LAT) m_cnt <= m_cnt + {{WIN_LOG2{1'b0}}, sn_bit(dp_op_a, dp_op_b)};
    end
  end

  function automatic logic [OP_W:0] exp_result(input int cnt);
    if (cnt >= WIN) return {1'b1, {OP_W{1'b0}}};
    return (OP_W+1)'((cnt * (1 << OP_W)) / WIN);
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; force_en = 1'b0; force_val = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_grant(output logic [1:0] g, output int cyc);
    g = 2'b00; cyc = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (grant != 2'b00) begin g = grant; cyc = i; return; end
    end
  endtask

  task automatic wait_rv(output int cyc, output int runs, output int clrs, output int grs);
    cyc = -1; runs = 0; clrs = 0; grs = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (dp_run) runs++;
      if (dp_clr) clrs++;
      if (grant != 2'b00) grs++;
      if (result_valid) begin cyc = i; return; end
    end
  endtask

  task automatic test_reset();
    logic [36:0] outs;
    rst = 1'b1; req = 2'b00; force_en = 1'b0; force_val = '0;
    op_a0 = '0; op_b0 = '0; op_a1 = '0; op_b1 = '0;
    @(negedge clk);
    outs = {grant, busy, dp_op_a, dp_op_b, dp_clr, dp_run, dp_seed_idx, result, result_valid, result_id};
    n_checks++;
    if (outs !== 37'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst = 1'b0;
    @(negedge clk);
    outs = {grant, busy, dp_op_a, dp_op_b, dp_clr, dp_run, dp_seed_idx, result, result_valid, result_id};
    n_checks++;
    if (outs !== 37'd0) begin n_fail++; $display("FAIL idle_after_reset: got %h want 0", outs); end
  endtask

  task automatic test_single();
    logic [1:0] g; int cyc, runs, clrs, grs;
    do_reset();
    op_a0 = 9'h1FF; op_b0 = 9'h1FF; op_a1 = 9'h055; op_b1 = 9'h0AA;
    req = 2'b01;
    wait_grant(g, cyc);
    n_checks++;
    if (g !== 2'b01 || cyc != 1) begin n_fail++; $display("FAIL single_grant: got %b after %0d want 01 after 1", g, cyc); end
    n_checks++;
    if (dp_clr !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL load_clr_busy: got clr=%b busy=%b want 1 1", dp_clr, busy); end
    req = 2'b00;
    wait_rv(cyc, runs, clrs, grs);
    n_checks++;
    if (cyc != LAT) begin n_fail++; $display("FAIL latency: got %0d want %0d", cyc, LAT); end
    n_checks++;
    if (runs != PIPE_LAT + WIN || clrs != 0 || grs != 0) begin
      n_fail++; $display("FAIL run_window: got run=%0d clr=%0d grant=%0d want %0d 0 0", runs, clrs, grs, PIPE_LAT + WIN);
    end
    n_checks++;
    if (m_cnt !== WIN[WIN_LOG2:0]) begin n_fail++; $display("FAIL counted_bits: got %0d want %0d", m_cnt, WIN); end
    n_checks++;
    if (result !== exp_result(WIN) || result_id !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_result: got %h id=%b busy=%b want %h id=0 busy=1", result, result_id, busy, exp_result(WIN));
    end
    n_checks++;
    if (dp_op_a !== 9'h1FF || dp_op_b !== 9'h1FF) begin n_fail++; $display("FAIL single_ops: got %h %h want 1ff 1ff", dp_op_a, dp_op_b); end
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp_result(WIN)) begin
      n_fail++; $display("FAIL after_done: got rv=%b busy=%b res=%h want 0 0 %h", result_valid, busy, result, exp_result(WIN));
    end
  endtask

  task automatic test_reset_mid_run();
    logic [1:0] g; int cyc, runs, clrs, grs, rv_seen;
    logic [36:0] outs;
    op_a0 = 9'h133; op_b0 = 9'h0F1; op_a1 = 9'h1C7; op_b1 = 9'h02B;
    req = 2'b01;
    wait_grant(g, cyc);
    req = 2'b00;
    repeat (PIPE_LAT + 6) @(negedge clk);
    rst = 1'b1;
    #1;
    outs = {grant, busy, dp_op_a, dp_op_b, dp_clr, dp_run, dp_seed_idx, result, result_valid, result_id};
    n_checks++;
    if (outs !== 37'd0) begin n_fail++; $display("FAIL mid_run_reset_outputs: got %h want 0", outs); end
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (result_valid || busy) rv_seen++;
    end
    n_checks++;
    if (rv_seen != 0) begin n_fail++; $display("FAIL mid_run_discard: got %0d active cycles want 0", rv_seen); end
    req = 2'b10;
    wait_grant(g, cyc);
    req = 2'b00;
    n_checks++;
    if (g !== 2'b10 || cyc != 1) begin n_fail++; $display("FAIL regrant_after_reset: got %b after %0d want 10 after 1", g, cyc); end
    wait_rv(cyc, runs, clrs, grs);
    n_checks++;
    if (cyc != LAT || result_id !== 1'b1 || result !== exp_result(int'(m_cnt))) begin
      n_fail++; $display("FAIL post_reset_job: got lat=%0d id=%b res=%h want %0d 1 %h", cyc, result_id, result, LAT, exp_result(int'(m_cnt)));
    end
  endtask

  task automatic test_alternate();
    logic [1:0] g; int cyc, runs, clrs, grs;
    int last_w, w;
    logic [OP_W-1:0] ea, eb;
    do_reset();
    op_a0 = 9'($urandom); op_b0 = 9'($urandom); op_a1 = 9'($urandom); op_b1 = 9'($urandom);
    last_w = 1;
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_grant(g, cyc);
      w = 1 - last_w;
      n_checks++;
      if (g !== 2'(1 << w)) begin n_fail++; $display("FAIL alt_grant%0d: got %b want %b", j, g, 2'(1 << w)); end
      ea = (w == 1) ? op_a1 : op_a0;
      eb = (w == 1) ? op_b1 : op_b0;
      req[w] = 1'b0;
      wait_rv(cyc, runs, clrs, grs);
      n_checks++;
      if (result_id !== w[0] || result !== exp_result(int'(m_cnt)) || dp_op_a !== ea || dp_op_b !== eb) begin
        n_fail++;
        $display("FAIL alt_result%0d: got id=%b res=%h ops=%h %h want id=%0d res=%h ops=%h %h",
                 j, result_id, result, dp_op_a, dp_op_b, w, exp_result(int'(m_cnt)), ea, eb);
      end
      last_w = w;
      if (w == 1) begin op_a1 = 9'($urandom); op_b1 = 9'($urandom); end
      else        begin op_a0 = 9'($urandom); op_b0 = 9'($urandom); end
      if (j < 3) req[w] = 1'b1;
      else       req = 2'b00;
    end
  endtask

  task automatic test_overflow();
    logic [1:0] g; int cyc, runs, clrs, grs;
    logic [WIN_LOG2:0] vals [4];
    vals[0] = 5'd17; vals[1] = 5'd9; vals[2] = 5'd16; vals[3] = 5'd0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      force_en = 1'b1; force_val = vals[k];
      req = 2'b01;
      wait_grant(g, cyc);
      req = 2'b00;
      wait_rv(cyc, runs, clrs, grs);
      n_checks++;
      if (result !== exp_result(int'(vals[k]))) begin
        n_fail++; $display("FAIL forced_ones_%0d: got %b want %b", vals[k], result, exp_result(int'(vals[k])));
      end
    end
    force_en = 1'b0;
  endtask

  task automatic test_busy_pulse();
    logic [1:0] g; int cyc, runs, clrs, grs, extra_g, extra_rv;
    do_reset();
    op_a0 = 9'($urandom); op_b0 = 9'($urandom);
    req = 2'b01;
    wait_grant(g, cyc);
    req = 2'b00;
    repeat (PIPE_LAT + 4) @(negedge clk);
    req = 2'b10;
    @(negedge clk);
    req = 2'b00;
    wait_rv(cyc, runs, clrs, grs);
    extra_g = grs; extra_rv = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (grant != 2'b00) extra_g++;
      if (result_valid) extra_rv++;
    end
    n_checks++;
    if (extra_g != 0 || extra_rv != 0) begin
      n_fail++; $display("FAIL busy_pulse: got grants=%0d results=%0d want 0 0", extra_g, extra_rv);
    end
  endtask

  task automatic test_seed();
    logic [1:0] g, exp_seed; int cyc, runs, clrs, grs;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      req = 2'b01;
      wait_grant(g, cyc);
      req = 2'b00;
`ifdef SC_SEED_ROTATE_EN
      exp_seed = 2'((j + 1) % 4);
`else
      exp_seed = 2'b00;
`endif
      n_checks++;
      if (dp_seed_idx !== exp_seed) begin n_fail++; $display("FAIL seed_job%0d: got %0d want %0d", j, dp_seed_idx, exp_seed); end
      wait_rv(cyc, runs, clrs, grs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_run();
    test_alternate();
    test_overflow();
    test_busy_pulse();
    test_seed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
